// File: rtl/mult_unit_if.sv
// Execute-stage multiply unit bus: operand/control inputs and HI/LO/done outputs.
interface mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_e;
    logic             signed_e;
    logic [WIDTH-1:0] srca_e;
    logic [WIDTH-1:0] srcb_e;
    logic             mthi_e;
    logic             mtlo_e;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             mult_done;

    modport master (
        output start_e, signed_e, srca_e, srcb_e, mthi_e, mtlo_e,
        input  hi_o, lo_o, mult_done
    );

    modport slave (
        input  start_e, signed_e, srca_e, srcb_e, mthi_e, mtlo_e,
        output hi_o, lo_o, mult_done
    );
endinterface

// File: rtl/mult_unit.sv
// Iterative radix-2 MULT/MULTU into HI/LO, with MTHI/MTLO writes while idle.
// state  | meaning
// IDLE   | no multiply outstanding; accepts start and MT writes
// BUSY   | one shift-add step per cycle, WIDTH steps
// FINISH | apply result sign and write HI:LO
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    mult_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH:0]   acc_q;
    logic               sign_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH:0]   acc_d;
    logic [2*WIDTH-1:0] res_d;

    always_comb begin
        a_mag_d = (bus.signed_e && bus.srca_e[WIDTH-1]) ? -bus.srca_e : bus.srca_e;
        b_mag_d = (bus.signed_e && bus.srcb_e[WIDTH-1]) ? -bus.srcb_e : bus.srcb_e;
        // Upper WIDTH+1 bits of the accumulator take the partial-product add.
        sum_d   = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_d   = {1'b0, sum_d, acc_q[WIDTH-1:1]};
        res_d   = sign_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_e) begin
                        mcand_q  <= a_mag_d;
                        mplier_q <= b_mag_d;
                        sign_q   <= bus.signed_e & (bus.srca_e[WIDTH-1] ^ bus.srcb_e[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end else begin
                        if (bus.mthi_e) hi_q <= bus.srca_e;
                        if (bus.mtlo_e) lo_q <= bus.srca_e;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= FINISH;
                end
                FINISH: begin
                    hi_q    <= res_d[2*WIDTH-1:WIDTH];
                    lo_q    <= res_d[WIDTH-1:0];
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;
    assign bus.mult_done = (state_q == IDLE);
endmodule
